uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling UART receiver. Frame = start(0), `width` data bits
//             LSB-first, optional parity bit, one stop bit(1). Each bit is
//             majority-voted from three samples around its centre. A good
//             frame updates P_Data and pulses Data_valid for one cycle; a bad
//             parity or stop bit pulses Parity_error / Stop_error instead.
//  Ports    :
//    CLK          in   system clock, RX_IN sampled on rising edge
//    Reset        in   synchronous active-low reset
//    RX_IN        in   serial line (pre-synchronised), idles high
//    Prescale     in   CLK cycles per bit (8, 16 or 32)
//    Parity_EN    in   1 = frame carries a parity bit
//    Parity_type  in   0 = even, 1 = odd
//    P_Data       out  last correctly received word
//    Data_valid   out  one-cycle pulse, P_Data updated
//    Parity_error out  one-cycle pulse, parity mismatch
//    Stop_error   out  one-cycle pulse, stop bit sampled 0
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int width      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    output logic [width-1:0]      P_Data,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  Stop_error
);

    localparam int BIT_CNT_W = (width > 1) ? $clog2(width) : 1;
    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(width - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                  state_q,        state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q,     edge_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,      bit_cnt_d;
    logic [PRESCALE_W-1:0]   prescale_q,     prescale_d;
    logic                    par_en_q,       par_en_d;
    logic                    par_type_q,     par_type_d;
    logic                    samp0_q,        samp0_d;
    logic                    samp1_q,        samp1_d;
    logic [width-1:0]        shift_q,        shift_d;
    logic                    par_err_q,      par_err_d;
    logic                    stp_err_q,      stp_err_d;
    logic                    done_q,         done_d;
    logic [width-1:0]        p_data_q,       p_data_d;
    logic                    data_valid_q,   data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q,   stop_error_d;

    logic [PRESCALE_W-1:0]   w_last;
    logic [PRESCALE_W-1:0]   w_half;
    logic [PRESCALE_W-1:0]   w_samp0;
    logic [PRESCALE_W-1:0]   w_dec;
    logic                    w_at_last;
    logic                    w_at_dec;
    logic                    w_maj;
    logic                    w_par_exp;
    logic [width:0]          w_shift_in;

    // Sample points sit at P/2-1, P/2, P/2+1; the vote is taken on the third
    // sample using the live RX_IN, so no extra register is needed for it.
    // Illegal Prescale values still let the counter reach w_last eventually,
    // so every state always advances.
    assign w_last     = prescale_q - EDGE_ONE;
    assign w_half     = prescale_q >> 1;
    assign w_samp0    = w_half - EDGE_ONE;
    assign w_dec      = w_half + EDGE_ONE;
    assign w_at_last  = (edge_cnt_q == w_last);
    assign w_at_dec   = (edge_cnt_q == w_dec);
    assign w_maj      = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);
    assign w_par_exp  = (^shift_q) ^ par_type_q;
    assign w_shift_in = {w_maj, shift_q};

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        prescale_d     = prescale_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        samp0_d        = samp0_q;
        samp1_d        = samp1_q;
        shift_d        = shift_q;
        par_err_d      = par_err_q;
        stp_err_d      = stp_err_q;
        done_d         = 1'b0;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        // Frame resolution runs the cycle after the final stop tick, in
        // parallel with IDLE possibly starting the next frame.
        if (done_q) begin
            if (!par_err_q && !stp_err_q) begin
                p_data_d     = shift_q;
                data_valid_d = 1'b1;
            end else begin
                parity_error_d = par_err_q;
                stop_error_d   = stp_err_q;
            end
        end

        if (state_q != S_IDLE) begin
            if (edge_cnt_q == w_samp0) samp0_d = RX_IN;
            if (edge_cnt_q == w_half)  samp1_d = RX_IN;
            edge_cnt_d = w_at_last ? '0 : edge_cnt_q + EDGE_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    // The detecting cycle is tick 0 of the start bit.
                    state_d    = S_START;
                    edge_cnt_d = EDGE_ONE;
                    prescale_d = Prescale;
                    par_en_d   = Parity_EN;
                    par_type_d = Parity_type;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (w_at_dec && w_maj) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (w_at_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_at_dec) shift_d = w_shift_in[width:1];
                if (w_at_last) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_dec)  par_err_d = (w_maj != w_par_exp);
                if (w_at_last) state_d   = S_STOP;
            end
            S_STOP: begin
                if (w_at_dec) stp_err_d = ~w_maj;
                if (w_at_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q        <= S_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            prescale_q     <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            samp0_q        <= 1'b0;
            samp1_q        <= 1'b0;
            shift_q        <= '0;
            par_err_q      <= 1'b0;
            stp_err_q      <= 1'b0;
            done_q         <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            prescale_q     <= prescale_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            samp0_q        <= samp0_d;
            samp1_q        <= samp1_d;
            shift_q        <= shift_d;
            par_err_q      <= par_err_d;
            stp_err_q      <= stp_err_d;
            done_q         <= done_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_Data       = p_data_q;
    assign Data_valid   = data_valid_q;
    assign Parity_error = parity_error_q;
    assign Stop_error   = stop_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx. Edge index k is the
//             k-th rising CLK edge; a frame's cycle 0 is the edge at which the
//             receiver first sees the low start bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       Parity_EN = 1'b0;
    logic       Parity_type = 1'b0;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Parity_error;
    logic       Stop_error;

    uart_rx #(.width(8), .PRESCALE_W(6)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .Parity_EN    (Parity_EN),
        .Parity_type  (Parity_type),
        .P_Data       (P_Data),
        .Data_valid   (Data_valid),
        .Parity_error (Parity_error),
        .Stop_error   (Stop_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    int nchk = 0;
    int nerr = 0;

    // Pulse recorder, sampled on the falling edge.
    int         dv_n = 0;
    int         pe_n = 0;
    int         se_n = 0;
    int         pe_cyc = 0;
    int         se_cyc = 0;
    int         dv_cyc [4];
    logic [7:0] dv_dat [4];

    always @(negedge CLK) begin
        if (Data_valid === 1'b1) begin
            if (dv_n < 4) begin
                dv_cyc[dv_n] = cyc;
                dv_dat[dv_n] = P_Data;
            end
            dv_n = dv_n + 1;
        end
        if (Parity_error === 1'b1) begin
            pe_cyc = cyc;
            pe_n   = pe_n + 1;
        end
        if (Stop_error === 1'b1) begin
            se_cyc = cyc;
            se_n   = se_n + 1;
        end
    end

    task automatic clr_mon();
        dv_n = 0;
        pe_n = 0;
        se_n = 0;
        for (int i = 0; i < 4; i++) begin
            dv_cyc[i] = -1;
            dv_dat[i] = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Drives the first nbits bits of a frame, p cycles per bit; t0 = edge
    // index at which the start bit is first sampled.
    task automatic drive_frame(input logic [7:0] d, input int p, input bit has_par,
                               input bit par_bit, input bit stop_bit, input int nbits,
                               output int t0);
        logic b [0:10];
        int   n;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        n = 9;
        if (has_par) begin
            b[n] = par_bit;
            n    = n + 1;
        end
        b[n] = stop_bit;
        n    = n + 1;
        if (nbits < n) n = nbits;
        t0 = 0;
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < p; r++) begin
                @(negedge CLK);
                RX_IN = b[k];
                if (k == 0 && r == 0) t0 = cyc + 1;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge CLK);
        nchk++; if (P_Data !== 8'h00) begin nerr++; $display("FAIL reset_pdata: got %h expected 00", P_Data); end
        nchk++; if (Data_valid !== 1'b0) begin nerr++; $display("FAIL reset_dv: got %b expected 0", Data_valid); end
        nchk++; if (Parity_error !== 1'b0) begin nerr++; $display("FAIL reset_pe: got %b expected 0", Parity_error); end
        nchk++; if (Stop_error !== 1'b0) begin nerr++; $display("FAIL reset_se: got %b expected 0", Stop_error); end
        Reset = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        int t0;
        Prescale = 6'd8; Parity_EN = 1'b0; Parity_type = 1'b0;
        clr_mon();
        drive_frame(8'hA5, 8, 0, 0, 1, 99, t0);
        idle(6);
        nchk++; if (dv_n !== 1) begin nerr++; $display("FAIL basic_dv_count: got %0d expected 1", dv_n); end
        nchk++; if (dv_cyc[0] - t0 !== 80) begin nerr++; $display("FAIL basic_dv_cycle: got %0d expected 80", dv_cyc[0] - t0); end
        nchk++; if (dv_dat[0] !== 8'hA5) begin nerr++; $display("FAIL basic_data: got %h expected a5", dv_dat[0]); end
        nchk++; if (pe_n + se_n !== 0) begin nerr++; $display("FAIL basic_err_pulses: got %0d expected 0", pe_n + se_n); end
    endtask

    task automatic test_parity();
        int t0;
        Prescale = 6'd16; Parity_EN = 1'b1; Parity_type = 1'b0;
        clr_mon();
        drive_frame(8'h3C, 16, 1, 0, 1, 99, t0);
        idle(6);
        nchk++; if (dv_n !== 1) begin nerr++; $display("FAIL even_dv_count: got %0d expected 1", dv_n); end
        nchk++; if (dv_cyc[0] - t0 !== 176) begin nerr++; $display("FAIL even_dv_cycle: got %0d expected 176", dv_cyc[0] - t0); end
        nchk++; if (dv_dat[0] !== 8'h3C) begin nerr++; $display("FAIL even_data: got %h expected 3c", dv_dat[0]); end
        nchk++; if (pe_n !== 0) begin nerr++; $display("FAIL even_no_pe: got %0d expected 0", pe_n); end
        clr_mon();
        drive_frame(8'h3C, 16, 1, 1, 1, 99, t0);
        idle(6);
        nchk++; if (pe_n !== 1) begin nerr++; $display("FAIL bad_par_pe_count: got %0d expected 1", pe_n); end
        nchk++; if (pe_cyc - t0 !== 176) begin nerr++; $display("FAIL bad_par_pe_cycle: got %0d expected 176", pe_cyc - t0); end
        nchk++; if (dv_n !== 0) begin nerr++; $display("FAIL bad_par_no_dv: got %0d expected 0", dv_n); end
        nchk++; if (se_n !== 0) begin nerr++; $display("FAIL bad_par_no_se: got %0d expected 0", se_n); end
        nchk++; if (P_Data !== 8'h3C) begin nerr++; $display("FAIL bad_par_pdata_held: got %h expected 3c", P_Data); end
    endtask

    task automatic test_odd_stop();
        int t0;
        Prescale = 6'd8; Parity_EN = 1'b1; Parity_type = 1'b1;
        clr_mon();
        drive_frame(8'h01, 8, 1, 0, 1, 99, t0);
        idle(6);
        nchk++; if (dv_n !== 1) begin nerr++; $display("FAIL odd_dv_count: got %0d expected 1", dv_n); end
        nchk++; if (dv_cyc[0] - t0 !== 88) begin nerr++; $display("FAIL odd_dv_cycle: got %0d expected 88", dv_cyc[0] - t0); end
        nchk++; if (dv_dat[0] !== 8'h01) begin nerr++; $display("FAIL odd_data: got %h expected 01", dv_dat[0]); end
        nchk++; if (pe_n !== 0) begin nerr++; $display("FAIL odd_no_pe: got %0d expected 0", pe_n); end
        clr_mon();
        drive_frame(8'h01, 8, 1, 0, 0, 99, t0);
        idle(6);
        nchk++; if (se_n !== 1) begin nerr++; $display("FAIL stop_se_count: got %0d expected 1", se_n); end
        nchk++; if (se_cyc - t0 !== 88) begin nerr++; $display("FAIL stop_se_cycle: got %0d expected 88", se_cyc - t0); end
        nchk++; if (pe_n + dv_n !== 0) begin nerr++; $display("FAIL stop_other_pulses: got %0d expected 0", pe_n + dv_n); end
        nchk++; if (P_Data !== 8'h01) begin nerr++; $display("FAIL stop_pdata_held: got %h expected 01", P_Data); end
        Parity_EN = 1'b0; Parity_type = 1'b0;
    endtask

    task automatic test_glitch();
        int t0;
        Prescale = 6'd8; Parity_EN = 1'b0;
        clr_mon();
        repeat (2) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        idle(120);
        nchk++; if (dv_n + pe_n + se_n !== 0) begin nerr++; $display("FAIL glitch_no_pulse: got %0d expected 0", dv_n + pe_n + se_n); end
        drive_frame(8'h55, 8, 0, 0, 1, 99, t0);
        idle(6);
        nchk++; if (dv_n !== 1) begin nerr++; $display("FAIL glitch_next_dv_count: got %0d expected 1", dv_n); end
        nchk++; if (dv_cyc[0] - t0 !== 80) begin nerr++; $display("FAIL glitch_next_dv_cycle: got %0d expected 80", dv_cyc[0] - t0); end
        nchk++; if (dv_dat[0] !== 8'h55) begin nerr++; $display("FAIL glitch_next_data: got %h expected 55", dv_dat[0]); end
    endtask

    task automatic test_back_to_back();
        int t0a;
        int t0b;
        Prescale = 6'd8; Parity_EN = 1'b0;
        clr_mon();
        drive_frame(8'h12, 8, 0, 0, 1, 99, t0a);
        drive_frame(8'hEF, 8, 0, 0, 1, 99, t0b);
        idle(6);
        nchk++; if (dv_n !== 2) begin nerr++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_n); end
        nchk++; if (dv_cyc[0] - t0a !== 80) begin nerr++; $display("FAIL b2b_dv0_cycle: got %0d expected 80", dv_cyc[0] - t0a); end
        nchk++; if (dv_dat[0] !== 8'h12) begin nerr++; $display("FAIL b2b_data0: got %h expected 12", dv_dat[0]); end
        nchk++; if (dv_cyc[1] - t0a !== 160) begin nerr++; $display("FAIL b2b_dv1_cycle: got %0d expected 160", dv_cyc[1] - t0a); end
        nchk++; if (dv_dat[1] !== 8'hEF) begin nerr++; $display("FAIL b2b_data1: got %h expected ef", dv_dat[1]); end

        // Prescale switches to 16 in the middle of the first frame; the second
        // frame is sent at 16 cycles per bit.
        clr_mon();
        fork
            begin
                drive_frame(8'h12, 8, 0, 0, 1, 99, t0a);
                drive_frame(8'hEF, 16, 0, 0, 1, 99, t0b);
            end
            begin
                repeat (40) @(negedge CLK);
                Prescale = 6'd16;
            end
        join
        idle(6);
        nchk++; if (dv_n !== 2) begin nerr++; $display("FAIL chg_dv_count: got %0d expected 2", dv_n); end
        nchk++; if (dv_cyc[0] - t0a !== 80) begin nerr++; $display("FAIL chg_dv0_cycle: got %0d expected 80", dv_cyc[0] - t0a); end
        nchk++; if (dv_dat[0] !== 8'h12) begin nerr++; $display("FAIL chg_data0: got %h expected 12", dv_dat[0]); end
        nchk++; if (dv_cyc[1] - t0a !== 240) begin nerr++; $display("FAIL chg_dv1_cycle: got %0d expected 240", dv_cyc[1] - t0a); end
        nchk++; if (dv_dat[1] !== 8'hEF) begin nerr++; $display("FAIL chg_data1: got %h expected ef", dv_dat[1]); end
        Prescale = 6'd8;
    endtask

    task automatic test_reset_midframe();
        int t0;
        Prescale = 6'd8; Parity_EN = 1'b0;
        clr_mon();
        // Start bit plus data bits 0..3, then reset during data bit 4.
        drive_frame(8'h96, 8, 0, 0, 1, 5, t0);
        @(negedge CLK);
        RX_IN = 1'b1;
        Reset = 1'b0;
        @(negedge CLK);
        nchk++; if (P_Data !== 8'h00) begin nerr++; $display("FAIL midrst_pdata: got %h expected 00", P_Data); end
        nchk++; if ({Data_valid, Parity_error, Stop_error} !== 3'b000) begin nerr++; $display("FAIL midrst_pulses: got %b expected 000", {Data_valid, Parity_error, Stop_error}); end
        Reset = 1'b1;
        RX_IN = 1'b1;
        idle(100);
        nchk++; if (dv_n + pe_n + se_n !== 0) begin nerr++; $display("FAIL midrst_no_pulse: got %0d expected 0", dv_n + pe_n + se_n); end
        drive_frame(8'h96, 8, 0, 0, 1, 99, t0);
        idle(6);
        nchk++; if (dv_n !== 1) begin nerr++; $display("FAIL midrst_next_dv_count: got %0d expected 1", dv_n); end
        nchk++; if (dv_cyc[0] - t0 !== 80) begin nerr++; $display("FAIL midrst_next_dv_cycle: got %0d expected 80", dv_cyc[0] - t0); end
        nchk++; if (dv_dat[0] !== 8'h96) begin nerr++; $display("FAIL midrst_next_data: got %h expected 96", dv_dat[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_odd_stop();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
